// File: rtl/note_lane_renderer.sv
// note_lane_renderer: 4-lane falling-note table with hit/miss scoring and a 1-cycle RGB render stage.
// Define MISS_FLASH_EN to tint the lane area red for 8 frames after any miss.
module note_lane_renderer #(
  parameter int V_ACTIVE = 480,
  parameter int NOTE_SLOTS = 8,
  parameter int SPEED = 2,
  parameter int LANE_X0 = 192,
  parameter int LANE_W = 64,
  parameter int NOTE_H = 16,
  parameter int STRIKE_Y = 416
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       spawn_valid,
  input  logic [1:0] spawn_lane,
  output logic       spawn_ready,
  input  logic [3:0] button,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt
);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] NH = 11'(NOTE_H);
  localparam logic [10:0] SY = 11'(STRIKE_Y);
  localparam logic [10:0] LX_LO = 11'(LANE_X0);
  localparam logic [10:0] LX_HI = 11'(LANE_X0 + 4 * LANE_W);
  logic [NOTE_SLOTS-1:0] valid_q, valid_d, zone, hit;
  logic [1:0] lane_q [NOTE_SLOTS];
  logic [1:0] lane_d [NOTE_SLOTS];
  logic [9:0] y_q [NOTE_SLOTS];
  logic [9:0] y_d [NOTE_SLOTS];
  logic [3:0] btn_q, rise, lane_col;
  logic [2:0] hits;
  logic [4:0] misses;
  logic [8:0] hit_sum, miss_sum;
  logic [7:0] hit_q, miss_q;
  logic [11:0] rgb_q, rgb_d, note_rgb;
  logic [10:0] px, py;
  logic found, spawned, note_on, divider, in_lanes, strike, flash, hs_q, vs_q;
  assign px = {1'b0, pixel_x};
  assign py = {1'b0, pixel_y};
  assign spawn_ready = ~&valid_q;
  assign {red, green, blue} = rgb_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign hit_cnt = hit_q;
  assign miss_cnt = miss_q;
  // Each lane's rising edge claims at most one note: the lowest-index one overlapping the strike zone.
  always_comb begin
    rise = button & ~btn_q;
    hit = '0;
    hits = '0;
    found = 1'b0;
    for (int i = 0; i < NOTE_SLOTS; i++)
      zone[i] = ({1'b0, y_q[i]} + NH > SY) && ({1'b0, y_q[i]} < SY + NH);
    for (int l = 0; l < 4; l++) begin
      found = 1'b0;
      for (int i = 0; i < NOTE_SLOTS; i++)
        if (!found && rise[l] && valid_q[i] && lane_q[i] == 2'(l) && zone[i]) begin
          hit[i] = 1'b1;
          found = 1'b1;
        end
      hits = hits + {2'b0, found};
    end
  end
  always_comb begin
    valid_d = valid_q;
    lane_d = lane_q;
    y_d = y_q;
    misses = '0;
    spawned = 1'b0;
    for (int i = 0; i < NOTE_SLOTS; i++)
      if (hit[i]) valid_d[i] = 1'b0;
      else if (frame_tick && valid_q[i]) begin
        if ({1'b0, y_q[i]} + SP >= VA) begin
          valid_d[i] = 1'b0;
          misses = misses + 5'd1;
        end else y_d[i] = y_q[i] + SP[9:0];
      end
    // Free slots are picked from registered state, so a slot freed this cycle waits a cycle.
    for (int i = 0; i < NOTE_SLOTS; i++)
      if (spawn_valid && !spawned && !valid_q[i]) begin
        valid_d[i] = 1'b1;
        lane_d[i] = spawn_lane;
        y_d[i] = '0;
        spawned = 1'b1;
      end
    hit_sum = {1'b0, hit_q} + {6'b0, hits};
    miss_sum = {1'b0, miss_q} + {4'b0, misses};
  end
  always_comb begin
    for (int l = 0; l < 4; l++)
      lane_col[l] = px >= 11'(LANE_X0 + l * LANE_W + 4) && px < 11'(LANE_X0 + (l + 1) * LANE_W - 4);
    note_on = 1'b0;
    note_rgb = '0;
    for (int i = 0; i < NOTE_SLOTS; i++)
      if (!note_on && valid_q[i] && lane_col[lane_q[i]] && py >= {1'b0, y_q[i]} && py < {1'b0, y_q[i]} + NH) begin
        note_on = 1'b1;
        note_rgb = lane_q[i] == 2'd0 ? 12'h0F0 : lane_q[i] == 2'd1 ? 12'hF00 : lane_q[i] == 2'd2 ? 12'hFF0 : 12'h00F;
      end
    divider = 1'b0;
    for (int k = 0; k < 5; k++)
      divider = divider | (px == 11'(LANE_X0 + k * LANE_W));
    in_lanes = px >= LX_LO && px < LX_HI;
    strike = py >= SY && py < SY + 11'd2 && in_lanes;
    rgb_d = !video_on ? 12'h000 : note_on ? note_rgb : strike ? 12'hFFF : divider ? 12'h444 : flash ? 12'h300 : 12'h000;
  end
`ifdef MISS_FLASH_EN
  logic [3:0] flash_q;
  assign flash = flash_q != 4'd0 && in_lanes;
  always_ff @(posedge clock)
    if (reset) flash_q <= '0;
    else if (misses != 5'd0) flash_q <= 4'd8;
    else if (frame_tick && flash_q != 4'd0) flash_q <= flash_q - 4'd1;
`else
  assign flash = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NOTE_SLOTS; i++) begin
        lane_q[i] <= '0;
        y_q[i] <= '0;
      end
      btn_q <= 4'hF;
      hit_q <= '0;
      miss_q <= '0;
      rgb_q <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      lane_q <= lane_d;
      y_q <= y_d;
      btn_q <= button;
      hit_q <= hit_sum > 9'd255 ? 8'hFF : hit_sum[7:0];
      miss_q <= miss_sum > 9'd255 ? 8'hFF : miss_sum[7:0];
      rgb_q <= rgb_d;
      hs_q <= hsync_in;
      vs_q <= vsync_in;
    end
  end
endmodule
